// File: rtl/envelope_controller.sv
// ADSR amplitude envelope: gate edges select the phase, and the amplitude
// steps by saturating WIDTH+1-bit arithmetic on each sample tick.
module envelope_controller #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             sample_tick,
  input  logic             gate,
  input  logic [WIDTH-1:0] peak_level,
  input  logic [WIDTH-1:0] sustain_level,
  input  logic [WIDTH-1:0] attack_step,
  input  logic [WIDTH-1:0] decay_step,
  input  logic [WIDTH-1:0] release_step,
  output logic [WIDTH-1:0] amplitude,
  output logic [2:0]       env_state,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_amp;
  logic             r_gate_q;
  logic             r_busy;

  logic             w_rise;
  logic             w_fall;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH:0]   w_attack_sum;
  logic [WIDTH:0]   w_decay_lim;
  logic [WIDTH:0]   w_amp_ext;
  state_t           w_next_state;
  logic [WIDTH-1:0] w_next_amp;

  assign w_rise       = gate & ~r_gate_q;
  assign w_fall       = ~gate & r_gate_q;
  assign w_target     = (sustain_level < peak_level) ? sustain_level : peak_level;
  assign w_amp_ext    = {1'b0, r_amp};
  // One extra bit keeps the sums from wrapping near full scale.
  assign w_attack_sum = w_amp_ext + {1'b0, attack_step};
  assign w_decay_lim  = {1'b0, w_target} + {1'b0, decay_step};

  // Next-state and next-amplitude selection; edges take priority over ticks.
  always_comb begin
    w_next_state = r_state;
    w_next_amp   = r_amp;
    if (w_rise) begin
      w_next_state = ATTACK;
    end else if (w_fall) begin
      if (r_state != IDLE) begin
        w_next_state = RELEASE;
      end else begin
        w_next_state = IDLE;
      end
    end else if (sample_tick) begin
      case (r_state)
        IDLE: begin
          w_next_amp = {WIDTH{1'b0}};
        end
        ATTACK: begin
          if ((attack_step == {WIDTH{1'b0}}) || (w_attack_sum >= {1'b0, peak_level})) begin
            w_next_amp   = peak_level;
            w_next_state = DECAY;
          end else begin
            w_next_amp = w_attack_sum[WIDTH-1:0];
          end
        end
        DECAY: begin
          if ((decay_step == {WIDTH{1'b0}}) || (w_amp_ext <= w_decay_lim)) begin
            w_next_amp   = w_target;
            w_next_state = SUSTAIN;
          end else begin
            w_next_amp = r_amp - decay_step;
          end
        end
        SUSTAIN: begin
          w_next_amp = w_target;
        end
        RELEASE: begin
          if ((release_step == {WIDTH{1'b0}}) || (r_amp <= release_step)) begin
            w_next_amp   = {WIDTH{1'b0}};
            w_next_state = IDLE;
          end else begin
            w_next_amp = r_amp - release_step;
          end
        end
        default: begin
          w_next_amp   = {WIDTH{1'b0}};
          w_next_state = IDLE;
        end
      endcase
    end else begin
      w_next_state = r_state;
      w_next_amp   = r_amp;
    end
  end

  // Envelope state, amplitude, busy flag and gate history registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_amp    <= {WIDTH{1'b0}};
      r_gate_q <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_amp    <= w_next_amp;
      r_gate_q <= gate;
      r_busy   <= (w_next_state != IDLE);
    end
  end

  assign amplitude = r_amp;
  assign env_state = r_state;
  assign busy      = r_busy;

endmodule

// File: tb/tb_envelope_controller.sv
// Directed bench for envelope_controller with hand-computed expectations.
module tb_envelope_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        sample_tick;
  logic        gate;
  logic [15:0] peak_level;
  logic [15:0] sustain_level;
  logic [15:0] attack_step;
  logic [15:0] decay_step;
  logic [15:0] release_step;
  logic [15:0] amplitude;
  logic [2:0]  env_state;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  envelope_controller #(.WIDTH(16)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .sample_tick   (sample_tick),
    .gate          (gate),
    .peak_level    (peak_level),
    .sustain_level (sustain_level),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .release_step  (release_step),
    .amplitude     (amplitude),
    .env_state     (env_state),
    .busy          (busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_env(input string tag, input logic [15:0] amp, input logic [2:0] st, input logic bsy);
    chk({tag, ".amp"}, {16'd0, amplitude}, {16'd0, amp});
    chk({tag, ".state"}, {29'd0, env_state}, {29'd0, st});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // One tick, then three quiet cycles; outputs are checked 1 unit after the tick edge.
  task automatic do_tick(input string tag, input logic [15:0] amp, input logic [2:0] st, input logic bsy);
    sample_tick = 1'b1;
    clk_n(1);
    sample_tick = 1'b0;
    chk_env(tag, amp, st, bsy);
    clk_n(3);
  endtask

  initial begin
    Reset = 1'b1; sample_tick = 1'b0; gate = 1'b0;
    peak_level = 16'h0000; sustain_level = 16'h0000;
    attack_step = 16'h0000; decay_step = 16'h0000; release_step = 16'h0000;
    clk_n(2);
    chk_env("reset", 16'h0000, 3'd0, 1'b0);
    Reset = 1'b0;
    clk_n(1);

    // Reset mid-attack takes effect without a clock edge
    peak_level = 16'h8000; sustain_level = 16'h4000;
    attack_step = 16'h1000; decay_step = 16'h1000; release_step = 16'h2000;
    gate = 1'b1;
    clk_n(1);
    chk_env("rst_atk_start", 16'h0000, 3'd1, 1'b1);
    do_tick("rst_atk1", 16'h1000, 3'd1, 1'b1);
    do_tick("rst_atk2", 16'h2000, 3'd1, 1'b1);
    do_tick("rst_atk3", 16'h3000, 3'd1, 1'b1);
    #2 Reset = 1'b1;
    #1;
    chk_env("async_reset", 16'h0000, 3'd0, 1'b0);
    gate = 1'b0;
    clk_n(2);
    Reset = 1'b0;
    clk_n(1);

    // Full ADSR
    attack_step = 16'h3000;
    gate = 1'b1;
    clk_n(1);
    chk_env("adsr_gate", 16'h0000, 3'd1, 1'b1);
    do_tick("adsr_a1", 16'h3000, 3'd1, 1'b1);
    do_tick("adsr_a2", 16'h6000, 3'd1, 1'b1);
    do_tick("adsr_a3", 16'h8000, 3'd2, 1'b1);
    do_tick("adsr_d1", 16'h7000, 3'd2, 1'b1);
    do_tick("adsr_d2", 16'h6000, 3'd2, 1'b1);
    do_tick("adsr_d3", 16'h5000, 3'd2, 1'b1);
    do_tick("adsr_d4", 16'h4000, 3'd3, 1'b1);
    sustain_level = 16'h3000;
    do_tick("adsr_sus_track", 16'h3000, 3'd3, 1'b1);
    sustain_level = 16'h4000;
    do_tick("adsr_sus_back", 16'h4000, 3'd3, 1'b1);
    gate = 1'b0;
    clk_n(1);
    chk_env("adsr_fall", 16'h4000, 3'd4, 1'b1);
    do_tick("adsr_r1", 16'h2000, 3'd4, 1'b1);
    do_tick("adsr_r2", 16'h0000, 3'd0, 1'b0);
    do_tick("adsr_idle", 16'h0000, 3'd0, 1'b0);

    // Saturation near full scale
    peak_level = 16'hFFFF; sustain_level = 16'hFFFF;
    attack_step = 16'hF000; decay_step = 16'h0000; release_step = 16'h0000;
    gate = 1'b1;
    clk_n(1);
    do_tick("sat_a1", 16'hF000, 3'd1, 1'b1);
    do_tick("sat_a2", 16'hFFFF, 3'd2, 1'b1);
    gate = 1'b0;
    clk_n(1);
    do_tick("sat_rel0", 16'h0000, 3'd0, 1'b0);

    // Instantaneous steps, sustain clamped to peak
    peak_level = 16'hA000; sustain_level = 16'hC000; attack_step = 16'h0000;
    gate = 1'b1;
    clk_n(1);
    do_tick("inst_a", 16'hA000, 3'd2, 1'b1);
    do_tick("inst_d", 16'hA000, 3'd3, 1'b1);
    gate = 1'b0;
    clk_n(1);
    chk_env("inst_fall", 16'hA000, 3'd4, 1'b1);
    do_tick("inst_r", 16'h0000, 3'd0, 1'b0);

    // Retrigger during release, rise coincident with tick
    peak_level = 16'h3000; sustain_level = 16'h3000; release_step = 16'h1000;
    gate = 1'b1;
    clk_n(1);
    do_tick("retrig_a", 16'h3000, 3'd2, 1'b1);
    do_tick("retrig_d", 16'h3000, 3'd3, 1'b1);
    gate = 1'b0;
    clk_n(1);
    chk_env("retrig_rel", 16'h3000, 3'd4, 1'b1);
    peak_level = 16'h8000; attack_step = 16'h1000;
    gate = 1'b1;
    do_tick("retrig_edge", 16'h3000, 3'd1, 1'b1);
    do_tick("retrig_step", 16'h4000, 3'd1, 1'b1);

    // Fall during attack at 0x2000
    gate = 1'b0; release_step = 16'h0000;
    clk_n(1);
    do_tick("fa_clear", 16'h0000, 3'd0, 1'b0);
    gate = 1'b1;
    clk_n(1);
    do_tick("fa_a1", 16'h1000, 3'd1, 1'b1);
    do_tick("fa_a2", 16'h2000, 3'd1, 1'b1);
    gate = 1'b0; release_step = 16'h0800;
    clk_n(1);
    chk_env("fa_fall", 16'h2000, 3'd4, 1'b1);
    do_tick("fa_r1", 16'h1800, 3'd4, 1'b1);
    do_tick("fa_r2", 16'h1000, 3'd4, 1'b1);
    do_tick("fa_r3", 16'h0800, 3'd4, 1'b1);
    do_tick("fa_r4", 16'h0000, 3'd0, 1'b0);

    // Gate high across reset release -> rise; peak_level=0 path
    Reset = 1'b1; gate = 1'b1;
    peak_level = 16'h0000; sustain_level = 16'h4000;
    attack_step = 16'h0100; decay_step = 16'h0100;
    clk_n(2);
    Reset = 1'b0;
    clk_n(1);
    chk_env("rst_gate_rise", 16'h0000, 3'd1, 1'b1);
    do_tick("pk0_a", 16'h0000, 3'd2, 1'b1);
    do_tick("pk0_d", 16'h0000, 3'd3, 1'b1);
    do_tick("pk0_s", 16'h0000, 3'd3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/envelope_controller.md
Name: envelope_controller

Overview:
- ADSR envelope sequencer for the synth's amplitude path.
- Takes the user-selected peak amplitude from the keyboard amplitude-select logic and a note gate (key held).
- Ramps a 16-bit amplitude through attack, decay, sustain and release on each audio sample strobe.
- Output feeds the oscillator/DAC multiplier in place of the static amplitude.

Parameters:
- WIDTH, 16, amplitude, level and step width in bits.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-Clk strobe at the audio sample rate; amplitude changes only on these cycles.
- gate  in  1  note-on level (1 = key held).
- peak_level  in  WIDTH  attack target; unsigned.
- sustain_level  in  WIDTH  absolute sustain level; effective target = min(sustain_level, peak_level).
- attack_step  in  WIDTH  increment per tick in ATTACK; 0 = instantaneous.
- decay_step  in  WIDTH  decrement per tick in DECAY; 0 = instantaneous.
- release_step  in  WIDTH  decrement per tick in RELEASE; 0 = instantaneous.
- amplitude  out  WIDTH  current envelope value.
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- busy  out  1  env_state != IDLE.

Behaviour:
- Reset (async, any time, including mid-ramp):
  - amplitude=0, env_state=IDLE, internal gate_q=0, busy=0.
  - First edge detection after Reset deassert compares against gate_q=0, so a gate already high produces a rising edge.
- Edge detection:
  - gate_q <= gate every Clk.
  - rise = gate & ~gate_q; fall = ~gate & gate_q.
  - Edges are evaluated every Clk, not only on ticks.
- Edge priority:
  - On the cycle after rise: env_state=ATTACK from the current amplitude (retrigger from any state; no reset to 0).
  - On the cycle after fall: env_state=RELEASE from the current amplitude if state != IDLE; a fall while IDLE stays IDLE.
  - An edge in the same cycle as sample_tick wins; no amplitude step occurs that cycle.
- Amplitude steps (only on sample_tick with no edge; 1-cycle latency from tick to amplitude update):
  - All arithmetic is WIDTH+1 bits, unsigned, saturating; no wrap-around ever.
  - ATTACK: if attack_step==0 or amplitude+attack_step >= peak_level, then amplitude=peak_level and state becomes DECAY; else amplitude += attack_step.
  - ATTACK with amplitude already above peak_level (retrigger after peak lowered): amplitude=peak_level, state DECAY.
  - DECAY: target T=min(sustain_level, peak_level). If decay_step==0 or amplitude <= T+decay_step, then amplitude=T and state becomes SUSTAIN; else amplitude -= decay_step.
  - SUSTAIN: amplitude=T on each tick (tracks live changes to sustain/peak); state unchanged until fall.
  - RELEASE: if release_step==0 or amplitude <= release_step, then amplitude=0 and state becomes IDLE; else amplitude -= release_step.
  - IDLE: amplitude held at 0.
- Step and level inputs are sampled each tick; changing them mid-phase takes effect at the next tick.
- peak_level=0: ATTACK resolves to 0, then DECAY to 0, then SUSTAIN at 0 on successive ticks.
- No combinational path from inputs to amplitude; all outputs registered.

Test Plan:
- Reset mid-attack: gate=1, peak=0x8000, attack_step=0x1000, 3 ticks then assert Reset -> amplitude=0 and env_state=0 immediately (asynchronous), without waiting for a Clk edge.
- Full ADSR: peak=0x8000, sustain=0x4000, attack=0x3000, decay=0x1000, release=0x2000; gate high, ticks every 4 Clk -> attack 0x3000, 0x6000, 0x8000 (DECAY); decay 0x7000…0x4000 (SUSTAIN on the 4th decay tick); gate low -> RELEASE 0x2000, 0x0000, IDLE, busy=0.
- Saturation: peak=0xFFFF, attack_step=0xF000 -> 0xF000, then 0xFFFF (no wrap), state DECAY.
- Instant steps: all steps=0, peak=0xA000, sustain=0xC000 -> tick 1 amplitude=0xA000 (DECAY), tick 2 stays 0xA000 (SUSTAIN, since min(sustain, peak)=0xA000); gate low, next tick -> 0 (IDLE).
- Retrigger: in RELEASE at 0x3000, gate rise coincident with sample_tick -> no step that cycle, ATTACK; next tick with attack_step=0x1000 -> 0x4000.
- Fall during ATTACK at 0x2000 with release_step=0x0800 -> RELEASE; ticks give 0x1800, 0x1000, 0x0800, 0x0000 (IDLE).
